boot_load_seq: RTL and testbench

Boot sequencer and port owner for the dual-port Mem4K. After reset it streams a program image into memory through port A and appends a terminator word. It then releases the single-cycle core from reset and hands it port A for instruction fetch and port B for data. It ends the run on a fetch of the terminator or on a cycle-limit watchdog.

---
 rtl/boot_load_seq.sv | 263 ++++++++++++++++++++++++++
 tb/tb_boot_load_seq.sv | 328 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/boot_load_seq.sv
// boot_load_seq
// Boot sequencer and port owner for the dual-port Mem4K. It streams a program
// image into memory through port A and appends a terminator word. It then
// releases the core from reset and hands it port A (instruction fetch) and
// port B (data). The run ends when the core fetches the terminator, or when the
// cycle-limit watchdog expires.
//
// Build option: define BOOT_VERIFY_EN to add a read-back checksum pass (VERIFY)
// between TERM and RUN. Without it, TERM goes straight to RUN and there is no
// checksum logic.
//
// Ports
//   clk_base, rst                   clock, async active-low reset
//   s_valid/s_ready/s_data/s_last   program word stream
//   core_rst                        active-high reset to the core
//   core_iaddr/core_instr           core instruction fetch (port A in RUN)
//   core_dwr/dsize/daddr/dwdata/drdata  core data access (port B in RUN)
//   mA_*                            Mem4K port A (word only)
//   mB_*                            Mem4K port B
//   state, nwords                   status
//
// state | meaning
// ------+----------------------------------------------
// LOAD  | accept stream beats, write words on port A
// TERM  | write terminator after the last word
// VERIFY| read image back on port B, compare checksums
// RUN   | core out of reset, owns both ports
// DONE  | terminator fetched (terminal)
// TIMEOUT| cycle limit reached in RUN (terminal)
// ERR   | overflow or checksum mismatch (terminal)

`ifndef MM_ENB_W
`define MM_ENB_W 1'b1
`endif
`ifndef MM_ENB_R
`define MM_ENB_R 1'b0
`endif
`ifndef MW_Word
`define MW_Word 2'b10
`endif

module boot_load_seq #(
    parameter logic [31:0] BASE_ADDR   = 32'd2048,
    parameter logic [31:0] TERM_WORD   = 32'hFFFF0000,
    parameter int          MAX_WORDS   = 511,
    parameter int          CYCLE_LIMIT = 1024
) (
    input  logic        clk_base,
    input  logic        rst,
    input  logic        s_valid,
    output logic        s_ready,
    input  logic [31:0] s_data,
    input  logic        s_last,
    output logic        core_rst,
    input  logic [31:0] core_iaddr,
    output logic [31:0] core_instr,
    input  logic        core_dwr,
    input  logic [1:0]  core_dsize,
    input  logic [31:0] core_daddr,
    input  logic [31:0] core_dwdata,
    output logic [31:0] core_drdata,
    output logic        mA_EnWR,
    output logic [31:0] mA_ABus,
    output logic [31:0] mA_DBusW,
    input  logic [31:0] mA_DBusR,
    output logic        mB_EnWR,
    output logic [1:0]  mB_Size,
    output logic [31:0] mB_ABus,
    output logic [31:0] mB_DBusW,
    input  logic [31:0] mB_DBusR,
    output logic [2:0]  state,
    output logic [9:0]  nwords
);

    typedef enum logic [2:0] {
        ST_LOAD    = 3'd0,
        ST_TERM    = 3'd1,
        ST_VERIFY  = 3'd2,
        ST_RUN     = 3'd3,
        ST_DONE    = 3'd4,
        ST_TIMEOUT = 3'd5,
        ST_ERR     = 3'd6
    } state_t;

    localparam int                CYC_W    = (CYCLE_LIMIT > 2) ? $clog2(CYCLE_LIMIT) : 1;
    localparam logic [CYC_W-1:0]  CYC_LAST = CYC_W'(CYCLE_LIMIT - 1);
    localparam logic [9:0]        NW_MAX   = 10'(MAX_WORDS);

    state_t           r_state;
    state_t           w_state_nxt;
    logic             r_s_ready;
    logic             r_core_rst;
    logic             r_ma_enwr;
    logic [31:0]      r_ma_abus;
    logic [31:0]      r_ma_dbusw;
    logic [31:0]      r_core_instr;
    logic [9:0]       r_nwords;
    logic [CYC_W-1:0] r_cyc;

    logic             w_beat;
    logic [31:0]      w_wr_addr;
    logic             w_term_fetch;
    logic             w_cyc_last;

`ifdef BOOT_VERIFY_EN
    logic [9:0]       r_vcnt;
    logic [31:0]      r_chk_load;
    logic [31:0]      r_chk_rd;
    logic             w_vfy_end;
`endif

    assign w_beat       = (r_state == ST_LOAD) && r_s_ready && s_valid;
    // Next free word: the load target while loading, the terminator slot after.
    assign w_wr_addr    = BASE_ADDR + {20'd0, r_nwords, 2'b00};
    assign w_term_fetch = (core_iaddr == w_wr_addr);
    assign w_cyc_last   = (r_cyc == CYC_LAST);

`ifdef BOOT_VERIFY_EN
    // Reads issue for vcnt 0..n-1 and return for vcnt 1..n; compare at n+1.
    assign w_vfy_end = (r_vcnt == r_nwords + 10'd1);
`endif

    assign state      = r_state;
    assign nwords     = r_nwords;
    assign s_ready    = r_s_ready;
    assign core_rst   = r_core_rst;
    assign core_instr = r_core_instr;
    assign mA_EnWR    = r_ma_enwr;
    assign mA_ABus    = r_ma_abus;
    assign mA_DBusW   = r_ma_dbusw;

    always_ff @(posedge clk_base or negedge rst) begin
        if (!rst) begin
            r_state <= ST_LOAD;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        mB_EnWR     = `MM_ENB_R;
        mB_Size     = `MW_Word;
        mB_ABus     = 32'd0;
        mB_DBusW    = 32'd0;
        core_drdata = 32'd0;

        case (r_state)
            ST_LOAD: begin
                if (w_beat) begin
                    if (s_last) begin
                        w_state_nxt = ST_TERM;
                    end else if (r_nwords + 10'd1 == NW_MAX) begin
                        w_state_nxt = ST_ERR;
                    end
                end
            end
            ST_TERM: begin
`ifdef BOOT_VERIFY_EN
                w_state_nxt = ST_VERIFY;
`else
                w_state_nxt = ST_RUN;
`endif
            end
`ifdef BOOT_VERIFY_EN
            ST_VERIFY: begin
                if (r_vcnt < r_nwords) begin
                    mB_ABus = BASE_ADDR + {20'd0, r_vcnt, 2'b00};
                end
                if (w_vfy_end) begin
                    w_state_nxt = (r_chk_rd == r_chk_load) ? ST_RUN : ST_ERR;
                end
            end
`endif
            ST_RUN: begin
                mB_EnWR     = core_dwr ? `MM_ENB_W : `MM_ENB_R;
                mB_Size     = core_dsize;
                mB_ABus     = core_daddr;
                mB_DBusW    = core_dwdata;
                core_drdata = mB_DBusR;
                // Terminator fetch has priority over the watchdog.
                if (w_term_fetch) begin
                    w_state_nxt = ST_DONE;
                end else if (w_cyc_last) begin
                    w_state_nxt = ST_TIMEOUT;
                end
            end
            ST_DONE, ST_TIMEOUT, ST_ERR: begin
                w_state_nxt = r_state;
            end
            default: begin
                w_state_nxt = ST_ERR;
            end
        endcase
    end

    always_ff @(posedge clk_base or negedge rst) begin
        if (!rst) begin
            r_s_ready    <= 1'b0;
            r_core_rst   <= 1'b1;
            r_ma_enwr    <= `MM_ENB_R;
            r_ma_abus    <= 32'd0;
            r_ma_dbusw   <= 32'd0;
            r_core_instr <= 32'd0;
            r_nwords     <= 10'd0;
            r_cyc        <= '0;
        end else begin
            r_s_ready  <= (w_state_nxt == ST_LOAD);
            r_core_rst <= (w_state_nxt != ST_RUN);
            // Port A defaults to idle; states below override.
            r_ma_enwr  <= `MM_ENB_R;
            r_ma_abus  <= 32'd0;
            r_ma_dbusw <= 32'd0;
            case (r_state)
                ST_LOAD: begin
                    if (w_beat) begin
                        r_ma_enwr  <= `MM_ENB_W;
                        r_ma_abus  <= w_wr_addr;
                        r_ma_dbusw <= s_data;
                        r_nwords   <= r_nwords + 10'd1;
                    end
                end
                ST_TERM: begin
                    r_ma_enwr  <= `MM_ENB_W;
                    r_ma_abus  <= w_wr_addr;
                    r_ma_dbusw <= TERM_WORD;
                end
                ST_RUN: begin
                    r_core_instr <= mA_DBusR;
                    if (!w_cyc_last) begin
                        r_cyc <= r_cyc + 1'b1;
                    end
                    if (w_state_nxt == ST_RUN) begin
                        r_ma_abus <= core_iaddr;
                    end
                end
                default: begin
                end
            endcase
        end
    end

`ifdef BOOT_VERIFY_EN
    always_ff @(posedge clk_base or negedge rst) begin
        if (!rst) begin
            r_vcnt     <= 10'd0;
            r_chk_load <= 32'd0;
            r_chk_rd   <= 32'd0;
        end else begin
            if (w_beat) begin
                r_chk_load <= r_chk_load ^ s_data;
            end
            if (r_state == ST_VERIFY) begin
                r_vcnt <= r_vcnt + 10'd1;
                if ((r_vcnt != 10'd0) && (r_vcnt <= r_nwords)) begin
                    r_chk_rd <= r_chk_rd ^ mB_DBusR;
                end
            end
        end
    end
`endif

endmodule

// File: tb/tb_boot_load_seq.sv
// Directed bench for boot_load_seq with a behavioural dual-port Mem4K model.
`timescale 1ns/1ps

`ifndef MM_ENB_W
`define MM_ENB_W 1'b1
`endif
`ifndef MM_ENB_R
`define MM_ENB_R 1'b0
`endif
`ifndef MW_Word
`define MW_Word 2'b10
`endif

module tb_boot_load_seq;

    localparam logic [31:0] BASE  = 32'd2048;
    localparam logic [31:0] TERMW = 32'hFFFF0000;
    localparam int          LIMIT = 1024;
`ifdef BOOT_VERIFY_EN
    localparam int          RUN_LAT = 6;   // TERM + VERIFY(3 words + 2)
`else
    localparam int          RUN_LAT = 1;
`endif

    logic        clk_base;
    logic        rst;
    logic        s_valid;
    logic        s_ready;
    logic [31:0] s_data;
    logic        s_last;
    logic        core_rst;
    logic [31:0] core_iaddr;
    logic [31:0] core_instr;
    logic        core_dwr;
    logic [1:0]  core_dsize;
    logic [31:0] core_daddr;
    logic [31:0] core_dwdata;
    logic [31:0] core_drdata;
    logic        mA_EnWR;
    logic [31:0] mA_ABus;
    logic [31:0] mA_DBusW;
    logic [31:0] mA_DBusR;
    logic        mB_EnWR;
    logic [1:0]  mB_Size;
    logic [31:0] mB_ABus;
    logic [31:0] mB_DBusW;
    logic [31:0] mB_DBusR;
    logic [2:0]  state;
    logic [9:0]  nwords;

    logic [31:0] mem [0:1023];
    logic [31:0] rdb_raw;
    logic        mem_init;
    logic        corrupt_en;
    int          wr_a_cnt;
    int          saw_verify;
    int          n_checks;
    int          n_errors;

    boot_load_seq dut (
        .clk_base   (clk_base),
        .rst        (rst),
        .s_valid    (s_valid),
        .s_ready    (s_ready),
        .s_data     (s_data),
        .s_last     (s_last),
        .core_rst   (core_rst),
        .core_iaddr (core_iaddr),
        .core_instr (core_instr),
        .core_dwr   (core_dwr),
        .core_dsize (core_dsize),
        .core_daddr (core_daddr),
        .core_dwdata(core_dwdata),
        .core_drdata(core_drdata),
        .mA_EnWR    (mA_EnWR),
        .mA_ABus    (mA_ABus),
        .mA_DBusW   (mA_DBusW),
        .mA_DBusR   (mA_DBusR),
        .mB_EnWR    (mB_EnWR),
        .mB_Size    (mB_Size),
        .mB_ABus    (mB_ABus),
        .mB_DBusW   (mB_DBusW),
        .mB_DBusR   (mB_DBusR),
        .state      (state),
        .nwords     (nwords)
    );

    initial clk_base = 1'b0;
    always #5 clk_base = ~clk_base;

    // Mem4K model: synchronous read, write committed at the edge.
    always @(posedge clk_base) begin
        if (mem_init) begin
            for (int i = 0; i < 1024; i++) mem[i] <= 32'hA5A50000 | i;
            wr_a_cnt <= 0;
        end else begin
            if (mA_EnWR == `MM_ENB_W) begin
                mem[mA_ABus[11:2]] <= mA_DBusW;
                wr_a_cnt <= wr_a_cnt + 1;
            end
            if (mB_EnWR == `MM_ENB_W) mem[mB_ABus[11:2]] <= mB_DBusW;
        end
        mA_DBusR <= mem[mA_ABus[11:2]];
        rdb_raw  <= mem[mB_ABus[11:2]];
        if (state == 3'd2) saw_verify <= saw_verify + 1;
    end

    assign mB_DBusR = rdb_raw ^ {31'd0, (corrupt_en && state == 3'd2)};

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(negedge clk_base);
    endtask

    task automatic do_reset();
        rst = 1'b0; s_valid = 1'b0; s_last = 1'b0; s_data = 32'd0;
        core_dwr = 1'b0; core_daddr = 32'd0; core_dwdata = 32'd0;
        repeat (2) tick();
        rst = 1'b1;
        tick();
    endtask

    task automatic send(input logic [31:0] d, input logic last);
        s_valid = 1'b1; s_data = d; s_last = last;
        tick();
        s_valid = 1'b0; s_last = 1'b0;
    endtask

    task automatic wait_run();
        int n;
        n = 0;
        while (state != 3'd3 && n < 30) begin tick(); n++; end
        check("reach_run", 32'(state), 32'd3);
    endtask

    initial begin
        int n;
        rst = 1'b1; s_valid = 1'b0; s_data = 32'd0; s_last = 1'b0;
        core_iaddr = 32'd0; core_dwr = 1'b0; core_dsize = `MW_Word;
        core_daddr = 32'd0; core_dwdata = 32'd0;
        mem_init = 1'b0; corrupt_en = 1'b0; saw_verify = 0;
        n_checks = 0; n_errors = 0;
        #2 rst = 1'b0;
        tick(); mem_init = 1'b1;
        tick(); mem_init = 1'b0;

        // Reset values
        check("rst_state",   32'(state),    32'd0);
        check("rst_s_ready", 32'(s_ready),  32'd0);
        check("rst_core_rst",32'(core_rst), 32'd1);
        check("rst_mA_EnWR", 32'(mA_EnWR),  32'(`MM_ENB_R));
        check("rst_mA_ABus", mA_ABus,       32'd0);
        check("rst_mA_DBusW",mA_DBusW,      32'd0);
        check("rst_mB_EnWR", 32'(mB_EnWR),  32'(`MM_ENB_R));
        check("rst_mB_Size", 32'(mB_Size),  32'(`MW_Word));
        check("rst_mB_ABus", mB_ABus,       32'd0);
        check("rst_instr",   core_instr,    32'd0);
        check("rst_drdata",  core_drdata,   32'd0);
        check("rst_nwords",  32'(nwords),   32'd0);

        rst = 1'b1;
        tick();
        check("s_ready_rise", 32'(s_ready), 32'd1);

        // Three-word load with a 5-cycle gap
        send(32'h00500093, 1'b0);
        check("b0_we",   32'(mA_EnWR), 32'(`MM_ENB_W));
        check("b0_addr", mA_ABus,      32'd2048);
        check("b0_data", mA_DBusW,     32'h00500093);
        send(32'h00108113, 1'b0);
        check("b1_addr", mA_ABus,      32'd2052);
        for (int i = 0; i < 5; i++) begin
            tick();
            check("gap_no_write", 32'(mA_EnWR), 32'(`MM_ENB_R));
        end
        send(32'h002081B3, 1'b1);
        check("term_state",   32'(state),   32'd1);
        check("term_s_ready", 32'(s_ready), 32'd0);
        check("b2_addr",      mA_ABus,      32'd2056);
        check("nwords3",      32'(nwords),  32'd3);
        check("term_core_rst",32'(core_rst),32'd1);
        n = 0;
        while (core_rst && n < 20) begin tick(); n++; end
        check("core_rst_fall_lat", 32'(n), 32'(RUN_LAT));
        check("run_state", 32'(state), 32'd3);
        tick();
        check("mem2048", mem[512], 32'h00500093);
        check("mem2052", mem[513], 32'h00108113);
        check("mem2056", mem[514], 32'h002081B3);
        check("mem2060", mem[515], TERMW);
        check("porta_writes", 32'(wr_a_cnt), 32'd4);

        // Instruction fetch through port A
        core_iaddr = 32'd2052;
        n = 0;
        while (core_instr != 32'h00108113 && n < 4) begin tick(); n++; end
        check("fetch_2052", core_instr, 32'h00108113);

        // Data port pass-through
        core_daddr = 32'd2056; core_dwr = 1'b0; core_dsize = `MW_Word;
        #1;
        check("pb_addr", mB_ABus,          32'd2056);
        check("pb_rd",   32'(mB_EnWR),     32'(`MM_ENB_R));
        tick();
        check("drdata",  core_drdata,      32'h002081B3);
        core_daddr = 32'd64; core_dwr = 1'b1; core_dwdata = 32'hDEADBEEF; core_dsize = 2'b01;
        #1;
        check("pb_we",   32'(mB_EnWR),     32'(`MM_ENB_W));
        check("pb_size", 32'(mB_Size),     32'd1);
        check("pb_wdata",mB_DBusW,         32'hDEADBEEF);
        tick();
        core_dwr = 1'b0; core_dsize = `MW_Word; core_daddr = 32'd2056;
        check("mem64", mem[16], 32'hDEADBEEF);

        // Terminator fetch ends the run
        core_iaddr = 32'd2060;
        tick();
        check("done_state",   32'(state),    32'd4);
        check("done_core_rst",32'(core_rst), 32'd1);
        check("done_mA_ABus", mA_ABus,       32'd0);
        check("done_mA_EnWR", 32'(mA_EnWR),  32'(`MM_ENB_R));
        check("done_mB_ABus", mB_ABus,       32'd0);
        check("done_mB_Size", 32'(mB_Size),  32'(`MW_Word));
        check("done_drdata",  core_drdata,   32'd0);
        repeat (3) tick();
        check("done_sticky",  32'(state),    32'd4);

        // Watchdog timeout
        core_iaddr = 32'd100;
        do_reset();
        send(32'h11111111, 1'b1);
        wait_run();
        n = 0;
        while (state == 3'd3 && n < 2000) begin tick(); n++; end
        check("timeout_len",  32'(n),        32'(LIMIT));
        check("timeout_state",32'(state),    32'd5);
        check("timeout_crst", 32'(core_rst), 32'd1);

        // Terminator fetch on the last allowed cycle beats the watchdog
        core_iaddr = 32'd100;
        do_reset();
        send(32'h22222222, 1'b1);
        wait_run();
        repeat (LIMIT - 1) tick();
        check("last_cycle_run", 32'(state), 32'd3);
        core_iaddr = 32'd2052;
        tick();
        check("done_wins", 32'(state), 32'd4);

        // Overflow: 511 beats without s_last
        core_iaddr = 32'd0;
        do_reset();
        s_valid = 1'b1; s_last = 1'b0;
        for (int i = 0; i < 511; i++) begin
            s_data = 32'h10000000 + i;
            tick();
        end
        check("ovf_state",   32'(state),    32'd6);
        check("ovf_nwords",  32'(nwords),   32'd511);
        check("ovf_s_ready", 32'(s_ready),  32'd0);
        tick();
        check("ovf_last_word", mem[1022],   32'h100001FE);
        check("ovf_no_4092",   mem[1023],   32'hA5A503FF);
        repeat (3) tick();
        s_valid = 1'b0;
        check("ovf_sticky",  32'(state),    32'd6);
        check("ovf_core_rst",32'(core_rst), 32'd1);

        // Async reset during load
        do_reset();
        send(32'h33333333, 1'b0);
        send(32'h44444444, 1'b0);
        check("pre_abort_nwords", 32'(nwords), 32'd2);
        #2 rst = 1'b0;
        #1;
        check("abort_state",   32'(state),    32'd0);
        check("abort_nwords",  32'(nwords),   32'd0);
        check("abort_s_ready", 32'(s_ready),  32'd0);
        check("abort_mA_EnWR", 32'(mA_EnWR),  32'(`MM_ENB_R));
        check("abort_mA_ABus", mA_ABus,       32'd0);
        check("abort_core_rst",32'(core_rst), 32'd1);
        tick();
        rst = 1'b1;
        tick();
        check("release_nwords", 32'(nwords), 32'd0);
        check("release_ready",  32'(s_ready), 32'd1);

`ifdef BOOT_VERIFY_EN
        // Read-back corruption forces ERR
        do_reset();
        corrupt_en = 1'b1;
        send(32'h00500093, 1'b0);
        send(32'h00108113, 1'b0);
        send(32'h002081B3, 1'b1);
        tick();
        n = 0;
        while (state == 3'd2 && n < 20) begin tick(); n++; end
        corrupt_en = 1'b0;
        check("verify_len",     32'(n),     32'd5);
        check("verify_bad_err", 32'(state), 32'd6);
        do_reset();
        send(32'h00500093, 1'b0);
        send(32'h00108113, 1'b1);
        n = 0;
        while (state != 3'd3 && state != 3'd6 && n < 20) begin tick(); n++; end
        check("verify_ok_run",  32'(state), 32'd3);
`else
        check("no_verify_state", 32'(saw_verify), 32'd0);
`endif

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: time limit reached, got no finish expected finish");
        $fatal(1, "time limit");
    end

endmodule
